// File: rtl/mem_acc_if.sv
// ---------------------------------------------------------------------------
// mem_acc_if
//   Request/response/clear bundle for mem_acc_module.
//   Parameters:
//     WIDTH     data/accumulator width
//     SIZE      number of words; ADDR_BITS is derived from it (minimum 1)
//   Signals:
//     req_valid/req_ready   request handshake (accepted when both high at clk edge)
//     req_op                00 rd, 01 wr, 10 acc, 11 treated as rd
//     req_addr, req_data    word address, write data / addend
//     rsp_valid, rsp_data   one-cycle response pulse for rd/acc
//     clr_start, busy       clear request pulse, clear-in-progress flag
//     ovf                   sticky accumulate overflow flag
//   Modports: master (requester side), slave (memory side).
// ---------------------------------------------------------------------------
interface mem_acc_if #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 16
);
    localparam int ADDR_BITS = (SIZE < 2) ? 1 : $clog2(SIZE);

    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [ADDR_BITS-1:0] req_addr;
    logic [WIDTH-1:0]     req_data;
    logic                 rsp_valid;
    logic [WIDTH-1:0]     rsp_data;
    logic                 clr_start;
    logic                 busy;
    logic                 ovf;

    modport master (
        output req_valid, req_op, req_addr, req_data, clr_start,
        input  req_ready, rsp_valid, rsp_data, busy, ovf
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_data, clr_start,
        output req_ready, rsp_valid, rsp_data, busy, ovf
    );
endinterface

// File: rtl/mem_acc_module.sv
// ---------------------------------------------------------------------------
// mem_acc_module
//   Single-clock on-chip RAM holding accumulation results (SpMV y vector).
//   Supports read, write and read-modify-write accumulate (mem[a] += d),
//   plus a hardware sequencer that zeroes the whole memory.
//   Two-stage pipeline: stage 0 registers the request and the raw RAM read,
//   stage 1 computes the new value, commits it and emits the response.
//   A forwarding register keeps back-to-back ops to one address coherent.
//   Parameters:
//     WIDTH     data width (must match the interface WIDTH)
//     SIZE      number of words (must match the interface SIZE)
//     SATURATE  0: accumulate wraps, 1: accumulate clamps at all-ones
//   Ports:
//     clk       clock, rising edge
//     rst       asynchronous reset, active-high
//     bus       mem_acc_if slave modport (request, response, clear, status)
// ---------------------------------------------------------------------------
module mem_acc_module #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 16,
    parameter int SATURATE = 0
) (
    input  logic         clk,
    input  logic         rst,
    mem_acc_if.slave     bus
);
    localparam int ADDR_BITS = (SIZE < 2) ? 1 : $clog2(SIZE);
    localparam bit SAT_EN = (SATURATE != 0);

    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SIZE - 1);
    localparam logic [ADDR_BITS:0]   SIZE_EXT  = (ADDR_BITS + 1)'(SIZE);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } state_t;

    state_t               state;
    logic                 busy_q;
    logic [ADDR_BITS-1:0] clr_ptr;

    logic [WIDTH-1:0]     mem [SIZE];

    logic                 s1_valid;
    logic [1:0]           s1_op;
    logic [ADDR_BITS-1:0] s1_addr;
    logic [WIDTH-1:0]     s1_data;
    logic [WIDTH-1:0]     raw_q;
    logic                 fwd;
    logic [WIDTH-1:0]     fwd_val;

    logic                 rsp_valid_q;
    logic [WIDTH-1:0]     rsp_data_q;
    logic                 ovf_q;

    logic                 accept;
    logic                 req_in_range;
    logic                 s1_in_range;
    logic                 s1_writes;
    logic                 s1_responds;
    logic [WIDTH-1:0]     old_val;
    logic [WIDTH:0]       sum;
    logic                 acc_carry;
    logic [WIDTH-1:0]     new_val;
    logic                 clr_write;
    logic                 clear_done;
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_waddr;
    logic [WIDTH-1:0]     ram_wdata;

    // Requests are only taken in IDLE; a clear request wins over a
    // simultaneous request.
    assign bus.req_ready = (state == IDLE) && !bus.clr_start;
    assign accept        = bus.req_valid && bus.req_ready;

    assign req_in_range = {1'b0, bus.req_addr} < SIZE_EXT;
    assign s1_in_range  = {1'b0, s1_addr} < SIZE_EXT;
    assign s1_writes    = s1_valid && ((s1_op == OP_WR) || (s1_op == OP_ACC));
    assign s1_responds  = s1_valid && (s1_op != OP_WR);

    // The RAM read for an op issued right behind a write to the same word
    // is stale; the forwarded value replaces it.
    assign old_val   = fwd ? fwd_val : raw_q;
    assign sum       = {1'b0, old_val} + {1'b0, s1_data};
    assign acc_carry = sum[WIDTH];

    // Value stage 1 will leave in the addressed word (reads leave it as is).
    always_comb begin
        new_val = old_val;
        case (s1_op)
            OP_WR:   new_val = s1_data;
            OP_ACC:  new_val = (acc_carry && SAT_EN) ? '1 : sum[WIDTH-1:0];
            default: new_val = old_val;
        endcase
    end

    // Clear and pipeline commits never overlap: no request is accepted
    // while the sequencer runs, and DRAIN lets the last one commit first.
    assign clr_write  = (state == CLEAR);
    assign clear_done = clr_write && (clr_ptr == LAST_ADDR);
    assign ram_we     = clr_write || (s1_writes && s1_in_range);
    assign ram_waddr  = clr_write ? clr_ptr : s1_addr;
    assign ram_wdata  = clr_write ? '0 : new_val;

    // RAM array: one write and one registered read per cycle, no reset so
    // it maps onto simple dual-port block memory.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (accept) begin
            raw_q <= req_in_range ? mem[bus.req_addr] : '0;
        end
    end

    // Clear sequencer: wait one cycle for the in-flight op, then walk the
    // pointer across every word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            clr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_start) begin
                        state  <= DRAIN;
                        busy_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                end
                CLEAR: begin
                    if (clr_ptr == LAST_ADDR) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline registers, forwarding capture, response and overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_op       <= '0;
            s1_addr     <= '0;
            s1_data     <= '0;
            fwd         <= 1'b0;
            fwd_val     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_op   <= bus.req_op;
                s1_addr <= bus.req_addr;
                s1_data <= bus.req_data;
                fwd     <= s1_writes && (s1_addr == bus.req_addr);
                fwd_val <= new_val;
            end

            rsp_valid_q <= s1_responds;
            if (s1_responds) begin
                if (!s1_in_range) begin
                    rsp_data_q <= '0;
                end else if (s1_op == OP_ACC) begin
                    rsp_data_q <= new_val;
                end else begin
                    rsp_data_q <= old_val;
                end
            end

            if (clear_done) begin
                ovf_q <= 1'b0;
            end else if (s1_valid && (s1_op == OP_ACC) && s1_in_range && acc_carry) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mem_acc_module.sv
// ---------------------------------------------------------------------------
// tb_mem_acc_module
//   Drives a wrapping (SATURATE=0) and a saturating (SATURATE=1) instance
//   with identical stimulus. A sequential reference model updates a word
//   array on every accepted request and queues the expected response; a
//   separate monitor pops and compares whenever a response appears.
// ---------------------------------------------------------------------------
module tb_mem_acc_module;
    localparam int WIDTH = 8;
    localparam int SIZE  = 12;
    localparam int ABITS = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    localparam logic [1:0] RD  = 2'b00;
    localparam logic [1:0] WR  = 2'b01;
    localparam logic [1:0] ACC = 2'b10;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             ovf;
        int               due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mem_acc_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus_w ();
    mem_acc_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus_s ();

    mem_acc_module #(.WIDTH(WIDTH), .SIZE(SIZE), .SATURATE(0)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    mem_acc_module #(.WIDTH(WIDTH), .SIZE(SIZE), .SATURATE(1)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    exp_t        q_wrap[$];
    exp_t        q_sat[$];
    int unsigned mdl_mem[2][SIZE];
    bit          mdl_ovf[2];
    int          busy_cnt = 0;
    int          neg_cnt  = 0;
    int          checks   = 0;
    int          fails    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_inputs(input logic v, input logic [1:0] op, input logic [ABITS-1:0] a,
                              input logic [WIDTH-1:0] d, input logic clr);
        bus_w.req_valid = v;   bus_s.req_valid = v;
        bus_w.req_op    = op;  bus_s.req_op    = op;
        bus_w.req_addr  = a;   bus_s.req_addr  = a;
        bus_w.req_data  = d;   bus_s.req_data  = d;
        bus_w.clr_start = clr; bus_s.clr_start = clr;
    endtask

    // Reference: requests take effect one after another in acceptance order.
    task automatic model_accept(input logic [1:0] op, input logic [ABITS-1:0] a, input logic [WIDTH-1:0] d);
        for (int s = 0; s < 2; s++) begin
            int unsigned res;
            exp_t        e;
            res = 0;
            if (int'(a) < SIZE) begin
                if (op == WR) begin
                    mdl_mem[s][a] = d;
                end else if (op == ACC) begin
                    res = mdl_mem[s][a] + d;
                    if (res > MAXV) begin
                        mdl_ovf[s] = 1'b1;
                        res = (s == 1) ? MAXV : res - (MAXV + 1);
                    end
                    mdl_mem[s][a] = res;
                end else begin
                    res = mdl_mem[s][a];
                end
            end
            if (op != WR) begin
                e.data = res[WIDTH-1:0];
                e.ovf  = mdl_ovf[s];
                e.due  = neg_cnt + 2;
                if (s == 0) q_wrap.push_back(e);
                else        q_sat.push_back(e);
            end
        end
    endtask

    // One clock cycle of stimulus; readiness and busy are predicted by the
    // bench from the clear requests it has issued.
    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [ABITS-1:0] a,
                                 input logic [WIDTH-1:0] d, input logic clr);
        logic exp_ready;
        set_inputs(v, op, a, d, clr);
        @(negedge clk);
        exp_ready = (busy_cnt == 0) && !clr;
        check("req_ready", {31'b0, bus_w.req_ready}, {31'b0, exp_ready});
        check("req_ready_sat", {31'b0, bus_s.req_ready}, {31'b0, exp_ready});
        check("busy", {31'b0, bus_w.busy}, {31'b0, busy_cnt != 0});
        @(posedge clk);
        if (v && exp_ready) model_accept(op, a, d);
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                for (int s = 0; s < 2; s++) begin
                    mdl_ovf[s] = 1'b0;
                    for (int i = 0; i < SIZE; i++) mdl_mem[s][i] = 0;
                end
            end
        end else if (clr) begin
            busy_cnt = SIZE + 1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, RD, '0, '0, 1'b0);
    endtask

    task automatic full_clear();
        applyStimulus(1'b0, RD, '0, '0, 1'b1);
        idle(SIZE + 2);
    endtask

    // Reset drops anything in flight; memory is undefined afterwards until
    // the caller runs a clear.
    task automatic do_reset();
        rst = 1'b1;
        set_inputs(1'b0, RD, '0, '0, 1'b0);
        #2;
        check("rst_busy", {31'b0, bus_w.busy}, 32'd0);
        check("rst_rsp_valid", {31'b0, bus_w.rsp_valid}, 32'd0);
        check("rst_rsp_data", {24'b0, bus_w.rsp_data}, 32'd0);
        check("rst_ovf", {31'b0, bus_w.ovf}, 32'd0);
        check("rst_ovf_sat", {31'b0, bus_s.ovf}, 32'd0);
        check("rst_rsp_valid_sat", {31'b0, bus_s.rsp_valid}, 32'd0);
        q_wrap.delete();
        q_sat.delete();
        busy_cnt   = 0;
        mdl_ovf[0] = 1'b0;
        mdl_ovf[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic checkOutput(input int s, input logic v, input logic [WIDTH-1:0] d, input logic o);
        exp_t e;
        int   qsize;
        qsize = (s == 0) ? q_wrap.size() : q_sat.size();
        if (v) begin
            if (qsize == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_rsp dut%0d: got data %h, expected no response (t=%0t)", s, d, $time);
            end else begin
                if (s == 0) e = q_wrap.pop_front();
                else        e = q_sat.pop_front();
                check($sformatf("rsp_data dut%0d", s), {24'b0, d}, {24'b0, e.data});
                check($sformatf("ovf dut%0d", s), {31'b0, o}, {31'b0, e.ovf});
                check($sformatf("rsp_latency dut%0d", s), neg_cnt, e.due);
            end
        end else if (qsize > 0) begin
            e = (s == 0) ? q_wrap[0] : q_sat[0];
            if (e.due <= neg_cnt) begin
                checks++;
                fails++;
                $display("[TB] FAIL missing_rsp dut%0d: got no response, expected data %h (t=%0t)", s, e.data, $time);
                if (s == 0) void'(q_wrap.pop_front());
                else        void'(q_sat.pop_front());
            end
        end
    endtask

    // Monitor: runs on the falling edge, independent of the stimulus.
    always @(negedge clk) begin
        neg_cnt++;
        if (!rst) begin
            checkOutput(0, bus_w.rsp_valid, bus_w.rsp_data, bus_w.ovf);
            checkOutput(1, bus_s.rsp_valid, bus_s.rsp_data, bus_s.ovf);
        end
    end

    initial begin
        logic [1:0]       op;
        logic [ABITS-1:0] a;
        logic [WIDTH-1:0] d;
        logic             v;
        logic             clr;

        $display("[TB] start");
        do_reset();
        full_clear();

        // Write then read the same word back to back (forwarded).
        applyStimulus(1'b1, WR, 4'd3, 8'h10, 1'b0);
        applyStimulus(1'b1, RD, 4'd3, 8'h00, 1'b0);
        idle(3);

        // Four consecutive accumulates to one word, then read it.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, ACC, 4'd5, 8'h01, 1'b0);
        applyStimulus(1'b1, RD, 4'd5, 8'h00, 1'b0);
        idle(3);

        // Accumulate carry: wraps in one instance, clamps in the other.
        applyStimulus(1'b1, WR, 4'd0, 8'hF0, 1'b0);
        applyStimulus(1'b1, ACC, 4'd0, 8'h20, 1'b0);
        idle(3);
        check("ovf_sticky", {31'b0, bus_w.ovf}, 32'd1);
        check("ovf_sticky_sat", {31'b0, bus_s.ovf}, 32'd1);

        // Clear requested together with a write: write is dropped.
        applyStimulus(1'b1, WR, 4'd2, 8'h55, 1'b1);
        idle(SIZE + 1);
        check("ovf_after_clear", {31'b0, bus_w.ovf}, 32'd0);
        for (int i = 0; i < SIZE; i++) applyStimulus(1'b1, RD, ABITS'(i), 8'h00, 1'b0);
        idle(3);

        // Out-of-range addresses.
        applyStimulus(1'b1, WR, 4'd13, 8'h07, 1'b0);
        applyStimulus(1'b1, RD, 4'd13, 8'h00, 1'b0);
        applyStimulus(1'b1, ACC, 4'd13, 8'h01, 1'b0);
        applyStimulus(1'b1, RD, 4'd1, 8'h00, 1'b0);
        idle(3);

        // Randomised traffic, biased toward a few words to exercise forwarding.
        for (int i = 0; i < 500; i++) begin
            v   = ($urandom_range(0, 4) != 0);
            op  = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            d   = 8'($urandom_range(0, 255));
            clr = ($urandom_range(0, 79) == 0);
            applyStimulus(v, op, a, d, clr);
        end
        idle(SIZE + 4);

        // Reset with an accumulate in flight: its response must never appear.
        applyStimulus(1'b1, ACC, 4'd1, 8'h33, 1'b0);
        do_reset();
        idle(3);

        // Reset in the middle of a clear.
        applyStimulus(1'b0, RD, '0, '0, 1'b1);
        idle(4);
        do_reset();
        idle(3);
        full_clear();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, RD, ABITS'(i), 8'h00, 1'b0);
        applyStimulus(1'b1, ACC, 4'd1, 8'h42, 1'b0);
        idle(4);

        check("queue_empty_wrap", q_wrap.size(), 32'd0);
        check("queue_empty_sat", q_sat.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
